// File: rtl/pucch_seq_phase_gen.sv
// Sequential 24-point phase-index generator for the 12-element PUCCH
// low-PAPR sequence: k(n) = (3*phi(n) + 2*((m_tot*n) mod 12)) mod 24.
module pucch_seq_phase_gen #(
  parameter int unsigned SEQ_LEN = 12,
  parameter int unsigned PHI_W   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [SEQ_LEN*PHI_W-1:0]   i_phi,
  input  logic [3:0]                 i_m0,
  input  logic [3:0]                 i_mcs,
  input  logic [7:0]                 i_ncs,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [4:0]                 o_point_index,
  output logic [3:0]                 o_n,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned VEC_W = SEQ_LEN * PHI_W;
  localparam int unsigned T_W   = 6;
  localparam logic [3:0]  LAST_N = 4'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [VEC_W-1:0]   r_phi;
  logic [3:0]         r_m0;
  logic [3:0]         r_mcs;
  logic [7:0]         r_ncs;
  logic [3:0]         r_m_tot;
  logic [3:0]         r_acc;

  logic [8:0]         w_sum;
  logic [3:0]         w_m_tot;
  logic [3:0]         w_n_next;
  logic [4:0]         w_acc_sum;
  logic [3:0]         w_acc_next;
  logic [5:0]         w_shamt;
  logic [VEC_W-1:0]   w_phi_shift;
  logic [PHI_W-1:0]   w_phi_next;

  // Wrap 3*phi + 2*acc (range -9..31) into 0..23; illegal phi codes use the same arithmetic
  function automatic logic [4:0] k_calc(input logic [PHI_W-1:0] phi, input logic [3:0] acc);
    logic signed [T_W-1:0] p;
    logic signed [T_W-1:0] t;
    logic signed [T_W-1:0] k;
    p = $signed({{(T_W-PHI_W){phi[PHI_W-1]}}, phi});
    t = p + p + p + $signed({1'b0, acc, 1'b0});
    if (t < 0)
      k = t + 6'sd24;
    else if (t >= 6'sd24)
      k = t - 6'sd24;
    else
      k = t;
    return 5'(k);
  endfunction

  // Total cyclic shift, next element index, incremental accumulator and next phi entry
  always_comb begin
    w_sum       = 9'(r_m0) + 9'(r_mcs) + 9'(r_ncs);
    w_m_tot     = 4'(w_sum % 9'd12);
    w_n_next    = o_n + 4'd1;
    w_acc_sum   = 5'(r_acc) + 5'(r_m_tot);
    w_acc_next  = (w_acc_sum >= 5'd12) ? 4'(w_acc_sum - 5'd12) : 4'(w_acc_sum);
    w_shamt     = 6'(w_n_next) * 6'(PHI_W);
    w_phi_shift = r_phi >> w_shamt;
    w_phi_next  = w_phi_shift[PHI_W-1:0];
  end

  // Control FSM with registered beat outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_phi         <= '0;
      r_m0          <= '0;
      r_mcs         <= '0;
      r_ncs         <= '0;
      r_m_tot       <= '0;
      r_acc         <= '0;
      o_valid       <= 1'b0;
      o_point_index <= '0;
      o_n           <= '0;
      o_last        <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_phi   <= i_phi;
            r_m0    <= i_m0;
            r_mcs   <= i_mcs;
            r_ncs   <= i_ncs;
            o_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_m_tot       <= w_m_tot;
          r_acc         <= '0;
          o_n           <= '0;
          o_point_index <= k_calc(r_phi[PHI_W-1:0], 4'd0);
          o_last        <= 1'b0;
          o_valid       <= 1'b1;
          r_state       <= S_RUN;
        end
        S_RUN: begin
          if (o_valid && i_ready) begin
            if (o_n == LAST_N) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              o_n           <= w_n_next;
              r_acc         <= w_acc_next;
              o_point_index <= k_calc(w_phi_next, w_acc_next);
              o_last        <= (w_n_next == LAST_N);
            end
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
